axi_lite_initiator: RTL and testbench
=====================================

AXI_LITE_INITIATOR -- requirements
Module: axi_lite_initiator

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width; DATA_WIDTH is fixed at 32, strobe width 4.
REQ-002 Parameter RSP_TIMEOUT, default 1024, maximum cycles to wait for B or R before a synthesized error response; 0 disables the timeout.
REQ-003 Ports: clk in 1, the single clock; resetn in 1, asynchronous active-low reset.
REQ-004 Command ports: cmd_valid in 1; cmd_ready out 1; cmd_write in 1 (1=write, 0=read); cmd_addr in ADDR_WIDTH; cmd_wdata in 32; cmd_wstrb in 4.
REQ-005 Response ports: rsp_valid out 1; rsp_ready in 1; rsp_write out 1 (echoes the command type); rsp_rdata out 32; rsp_resp out 2 (AXI response code).
REQ-006 AXI write ports: awvalid out 1; awready in 1; awaddr out ADDR_WIDTH; wvalid out 1; wready in 1; wdata out 32; wstrb out 4; bvalid in 1; bready out 1; bresp in 2.
REQ-007 AXI read ports: arvalid out 1; arready in 1; araddr out ADDR_WIDTH; rvalid in 1; rready out 1; rdata in 32; rresp in 2.
REQ-008 Status ports: busy out 1, high in every state except IDLE; txn_count out 32, count of completed responses.

Function
REQ-009 States are IDLE, WRITE, WRESP, RADDR, RDATA and RESP. The block has one outstanding transaction at most.
REQ-010 cmd_ready is high only in IDLE. Handshake is cmd_valid && cmd_ready; on it, addr/wdata/wstrb/type are registered.
REQ-011 Write command: IDLE to WRITE; awvalid and wvalid both assert the next cycle with registered payloads.
REQ-012 In WRITE, awvalid drops the cycle after awready is sampled with awvalid; wvalid likewise with wready. The two handshakes complete independently, in either order or in the same cycle.
REQ-013 When both AW and W are done, the FSM goes to WRESP. bready is high only in WRESP.
REQ-014 In WRESP, bvalid captures bresp into rsp_resp and moves the FSM to RESP. rsp_rdata is 0 for writes.
REQ-015 Read command: IDLE to RADDR; arvalid is held with araddr until arready, then the FSM goes to RDATA.
REQ-016 rready is high only in RDATA. rvalid captures rdata and rresp, then the FSM goes to RESP.
REQ-017 AXI payload outputs stay stable while their valid is high. valid never drops before its ready is sampled.
REQ-018 In RESP, rsp_valid is high and holds stable until rsp_ready. On the handshake the FSM returns to IDLE and txn_count increments by 1, wrapping from 0xFFFFFFFF to 0.
REQ-019 The timeout counter is cleared on entry to WRESP or RDATA and increments each cycle in those states.
REQ-020 When the timeout counter reaches RSP_TIMEOUT (and RSP_TIMEOUT is nonzero), the FSM goes to RESP with rsp_resp=2'b11 and rsp_rdata=0.
REQ-021 A late B or R that arrives after a timeout is ignored, because bready and rready are low outside WRESP and RDATA.
REQ-022 The timeout does not apply in WRITE or RADDR; the address and data channels may stall indefinitely.
REQ-023 Minimum latency is 4 cycles from cmd handshake to rsp_valid, with zero-wait AXI responders (ready and B/R valid in the first eligible cycle).
REQ-024 A cmd_valid asserted in the same cycle as the rsp handshake is not accepted until the following cycle (IDLE).

Reset
REQ-025 resetn low asynchronously forces the state to IDLE, from any state including mid-transaction.
REQ-026 Under reset, all valid/ready outputs (awvalid, wvalid, bready, arvalid, rready, rsp_valid) are 0; cmd_ready is 1 after reset deassertion; busy is 0.
REQ-027 Under reset, txn_count, the timeout counter and all payload registers are 0.
REQ-028 Outputs leave reset values only on a clk edge after resetn is high. An in-flight AXI transaction aborted by reset is not completed.

Verification
REQ-029 Write, zero-wait responder: addr 0x100, data 0xDEADBEEF, strb 0xF -> AW and W handshakes in the same cycle; rsp_valid 4 cycles after the cmd handshake with rsp_write=1, rsp_resp=0; txn_count=1.
REQ-030 Write with wready delayed 3 cycles after awready -> awvalid drops first, wvalid held with stable data; a single response with rsp_resp equal to the bresp sent (e.g. 2'b10).
REQ-031 Read from 0x200, responder returns 0x12345678 after 5 cycles -> rsp_rdata=0x12345678, rsp_resp=0, rsp_write=0; rready high only in RDATA.
REQ-032 RSP_TIMEOUT=8, responder never asserts rvalid -> rsp_valid 8 cycles after entering RDATA with rsp_resp=2'b11 and rsp_rdata=0; a later rvalid is not accepted.
REQ-033 Back-to-back commands with rsp_ready held low 10 cycles -> response held stable and cmd_ready=0 throughout; txn_count increments once per rsp handshake; wrap tested by forcing 0xFFFFFFFF to 0.
REQ-034 resetn pulsed low while in WRESP -> all valids drop immediately; post-reset state IDLE, txn_count=0, cmd_ready=1.

Source files
------------

// File: rtl/axi_lite_initiator.sv
// Single-outstanding AXI4-Lite initiator: accepts one command, runs the AXI
// write or read handshakes, and returns one response (with optional B/R timeout).
module axi_lite_initiator #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned RSP_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  // Command channel
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]           cmd_wdata,
  input  logic [3:0]            cmd_wstrb,
  // Response channel
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [31:0]           rsp_rdata,
  output logic [1:0]            rsp_resp,
  // AXI write
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_WIDTH-1:0] awaddr,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  // AXI read
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  // Status
  output logic                  busy,
  output logic [31:0]           txn_count
);

  typedef enum logic [2:0] {
    StIdle, StWrite, StWresp, StRaddr, StRdata, StResp
  } state_e;

  localparam logic [31:0] TmoLast = 32'(RSP_TIMEOUT) - 32'd1;

  state_e                  state_q;
  logic                    cmd_ready_q, busy_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic                    rsp_valid_q, rsp_write_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [31:0]             wdata_q, rsp_rdata_q, txn_count_q, tmo_q;
  logic [3:0]              wstrb_q;
  logic [1:0]              rsp_resp_q;
  logic                    tmo_hit;

  // A zero RSP_TIMEOUT disables the timeout entirely.
  assign tmo_hit = (RSP_TIMEOUT != 0) && (tmo_q == TmoLast);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
      txn_count_q <= '0;
      tmo_q       <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            rsp_write_q <= cmd_write;
            if (cmd_write) begin
              state_q   <= StWrite;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              wstrb_q   <= cmd_wstrb;
            end else begin
              state_q   <= StRaddr;
              arvalid_q <= 1'b1;
              araddr_q  <= cmd_addr;
            end
          end
        end
        StWrite: begin
          // AW and W complete independently; leave once neither is pending.
          if (awvalid_q && awready) awvalid_q <= 1'b0;
          if (wvalid_q && wready)   wvalid_q  <= 1'b0;
          if ((!awvalid_q || awready) && (!wvalid_q || wready)) begin
            state_q  <= StWresp;
            bready_q <= 1'b1;
            tmo_q    <= '0;
          end
        end
        StWresp: begin
          if (bvalid || tmo_hit) begin
            state_q     <= StResp;
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= bvalid ? bresp : 2'b11;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        StRaddr: begin
          if (arready) begin
            state_q   <= StRdata;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            tmo_q     <= '0;
          end
        end
        StRdata: begin
          if (rvalid || tmo_hit) begin
            state_q     <= StResp;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= rvalid ? rdata : 32'd0;
            rsp_resp_q  <= rvalid ? rresp : 2'b11;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            txn_count_q <= txn_count_q + 32'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign bready    = bready_q;
  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign rready    = rready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;
  assign txn_count = txn_count_q;

endmodule

// File: tb/tb_axi_lite_initiator.sv
// Bench for axi_lite_initiator: cycle-level AXI responder plus a rule-based
// model of the expected handshakes, responses and transaction count.
module tb_axi_lite_initiator;

  localparam int unsigned AW  = 32;
  localparam int unsigned TMO = 8;

  logic          clk = 1'b0, resetn = 1'b0;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0, rsp_ready = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          awready = 1'b0, wready = 1'b0, bvalid = 1'b0, arready = 1'b0, rvalid = 1'b0;
  logic [1:0]    bresp = '0, rresp = '0;
  logic [31:0]   rdata = '0;
  logic          cmd_ready, rsp_valid, rsp_write, awvalid, wvalid, bready, arvalid, rready, busy;
  logic [31:0]   rsp_rdata, wdata, txn_count;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic [3:0]    wstrb;

  axi_lite_initiator #(.ADDR_WIDTH(AW), .RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .busy(busy), .txn_count(txn_count)
  );

  always #5 clk = ~clk;

  int          n_chk = 0, n_fail = 0;
  logic [31:0] exp_count = '0;

  // Results of the last run_txn call; cycle 1 is the command handshake cycle.
  logic [31:0] r_rdata;
  logic [1:0]  r_resp;
  logic        r_write;
  int          r_rsp_cyc, r_wait, r_aw_cyc, r_w_cyc, r_viol, r_late, r_hung;

  // Drives one command and plays the AXI slave; must be entered at a negedge.
  task automatic run_txn(input bit wr, input logic [31:0] addr, wd, input logic [3:0] st,
                         input int aw_lat, w_lat, ar_lat, d_lat, input logic [1:0] resp,
                         input logic [31:0] rd, input int hold, input bit b2b);
    bit aw_done, w_done, ar_done, d_done, rsp_seen, got, dv;
    bit aw_fire, w_fire, ar_fire, d_fire, rsp_fire, exp_b, exp_r;
    int aw_n, w_n, ar_n, d_n, hold_n, cyc, guard;
    logic [34:0] snap;
    {aw_done, w_done, ar_done, d_done, rsp_seen, got} = '0;
    {aw_fire, w_fire, ar_fire, d_fire, rsp_fire} = '0;
    {aw_n, w_n, ar_n, d_n, hold_n} = '0;
    snap = '0;
    r_viol = 0; r_late = 0; r_hung = 0; r_wait = -1; r_rsp_cyc = -1;
    r_aw_cyc = -1; r_w_cyc = -1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_wstrb = st;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    cyc = 1;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (aw_fire) begin aw_done = 1'b1; r_aw_cyc = cyc; end
      if (w_fire)  begin w_done = 1'b1;  r_w_cyc = cyc;  end
      if (ar_fire) ar_done = 1'b1;
      if (d_fire)  d_done = 1'b1;
      if (rsp_fire) got = 1'b1;
      if (got) break;
      cmd_valid = 1'b0;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) r_viol++;
      // Each valid is high from command accept until its own handshake.
      if (awvalid !== (wr && !aw_done)) r_viol++;
      if (wvalid !== (wr && !w_done)) r_viol++;
      if (arvalid !== (!wr && !ar_done)) r_viol++;
      if (awvalid === 1'b1 && awaddr !== addr) r_viol++;
      if (wvalid === 1'b1 && (wdata !== wd || wstrb !== st)) r_viol++;
      if (arvalid === 1'b1 && araddr !== addr) r_viol++;
      exp_b = wr && aw_done && w_done && !d_done && !(rsp_seen || rsp_valid === 1'b1);
      exp_r = !wr && ar_done && !d_done && !(rsp_seen || rsp_valid === 1'b1);
      if (bready !== exp_b || rready !== exp_r) r_viol++;
      if ((exp_b || exp_r) && r_wait < 0) r_wait = cyc;
      if (rsp_valid === 1'b1) begin
        if (!rsp_seen) begin
          rsp_seen = 1'b1;
          r_rsp_cyc = cyc;
          snap = {rsp_write, rsp_resp, rsp_rdata};
        end else if ({rsp_write, rsp_resp, rsp_rdata} !== snap) begin
          r_viol++;
        end
      end else if (rsp_seen) begin
        r_viol++;
      end
      // Slave side: ready after the programmed wait, B/R after the data latency.
      awready = 1'b0;
      if (awvalid === 1'b1) begin awready = (aw_n >= aw_lat); aw_n++; end
      wready = 1'b0;
      if (wvalid === 1'b1) begin wready = (w_n >= w_lat); w_n++; end
      arready = 1'b0;
      if (arvalid === 1'b1) begin arready = (ar_n >= ar_lat); ar_n++; end
      aw_fire = awvalid === 1'b1 && awready;
      w_fire  = wvalid === 1'b1 && wready;
      ar_fire = arvalid === 1'b1 && arready;
      dv = 1'b0;
      if ((wr ? (aw_done && w_done) : ar_done) && !d_done) begin
        dv = (d_n >= d_lat);
        d_n++;
      end
      bvalid = wr && dv;
      bresp  = bvalid ? resp : 2'b00;
      rvalid = !wr && dv;
      rdata  = rvalid ? rd : 32'd0;
      rresp  = rvalid ? resp : 2'b00;
      d_fire = wr ? (bvalid && bready === 1'b1) : (rvalid && rready === 1'b1);
      if (d_fire && rsp_seen) r_late++;
      rsp_ready = 1'b0;
      if (rsp_valid === 1'b1) begin rsp_ready = (hold_n >= hold); hold_n++; end
      rsp_fire = rsp_valid === 1'b1 && rsp_ready;
      if (rsp_fire && b2b) cmd_valid = 1'b1;
    end
    if (!got) r_hung = 1;
    r_write = snap[34];
    r_resp  = snap[33:32];
    r_rdata = snap[31:0];
    {awready, wready, bvalid, arready, rvalid, rsp_ready} = '0;
    bresp = '0; rresp = '0; rdata = '0;
    if (!b2b) cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_valids: got %b expected 0000000",
               {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy});
    end
    n_chk++;
    if ({txn_count, awaddr, wdata, wstrb, araddr, rsp_rdata, rsp_resp} !== '0) begin
      n_fail++;
      $display("FAIL reset_payload: got count=%h awaddr=%h wdata=%h rsp_rdata=%h expected 0",
               txn_count, awaddr, wdata, rsp_rdata);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
    exp_count = '0;
  endtask

  task automatic test_write_zero_wait();
    run_txn(1'b1, 32'h100, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 2'b00, 32'h0, 0, 1'b0);
    exp_count++;
    n_chk++;
    if (r_hung !== 0 || r_viol !== 0) begin
      n_fail++;
      $display("FAIL wr0_protocol: got hung=%0d viol=%0d expected 0 0", r_hung, r_viol);
    end
    n_chk++;
    if (r_aw_cyc !== r_w_cyc) begin
      n_fail++;
      $display("FAIL wr0_same_cycle: got aw=%0d w=%0d expected equal", r_aw_cyc, r_w_cyc);
    end
    n_chk++;
    if (r_rsp_cyc !== 4) begin
      n_fail++;
      $display("FAIL wr0_latency: got %0d expected 4", r_rsp_cyc);
    end
    n_chk++;
    if ({r_write, r_resp, r_rdata} !== {1'b1, 2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL wr0_rsp: got w=%b resp=%b rdata=%h expected 1 00 0",
               r_write, r_resp, r_rdata);
    end
    n_chk++;
    if (txn_count !== exp_count) begin
      n_fail++;
      $display("FAIL wr0_count: got %0d expected %0d", txn_count, exp_count);
    end
  endtask

  task automatic test_write_w_delay();
    run_txn(1'b1, 32'h0000_0A40, 32'hCAFE_F00D, 4'h5, 0, 3, 0, 1, 2'b10, 32'h0, 1, 1'b0);
    exp_count++;
    n_chk++;
    if (r_hung !== 0 || r_viol !== 0) begin
      n_fail++;
      $display("FAIL wdly_protocol: got hung=%0d viol=%0d expected 0 0", r_hung, r_viol);
    end
    n_chk++;
    if (r_w_cyc - r_aw_cyc !== 3) begin
      n_fail++;
      $display("FAIL wdly_order: got w-aw=%0d expected 3", r_w_cyc - r_aw_cyc);
    end
    n_chk++;
    if ({r_write, r_resp, r_rdata} !== {1'b1, 2'b10, 32'h0}) begin
      n_fail++;
      $display("FAIL wdly_rsp: got w=%b resp=%b rdata=%h expected 1 10 0",
               r_write, r_resp, r_rdata);
    end
    n_chk++;
    if (txn_count !== exp_count) begin
      n_fail++;
      $display("FAIL wdly_count: got %0d expected %0d", txn_count, exp_count);
    end
  endtask

  task automatic test_read();
    run_txn(1'b0, 32'h200, 32'h0, 4'h0, 0, 0, 1, 5, 2'b00, 32'h1234_5678, 0, 1'b0);
    exp_count++;
    n_chk++;
    if (r_hung !== 0 || r_viol !== 0) begin
      n_fail++;
      $display("FAIL rd_protocol: got hung=%0d viol=%0d expected 0 0", r_hung, r_viol);
    end
    n_chk++;
    if ({r_write, r_resp, r_rdata} !== {1'b0, 2'b00, 32'h1234_5678}) begin
      n_fail++;
      $display("FAIL rd_rsp: got w=%b resp=%b rdata=%h expected 0 00 12345678",
               r_write, r_resp, r_rdata);
    end
  endtask

  task automatic test_read_timeout();
    // R shows up 10 cycles into the wait, after the 8-cycle timeout has fired.
    run_txn(1'b0, 32'h300, 32'h0, 4'h0, 0, 0, 0, 10, 2'b00, 32'hA5A5_A5A5, 12, 1'b0);
    exp_count++;
    n_chk++;
    if (r_hung !== 0 || r_viol !== 0) begin
      n_fail++;
      $display("FAIL tmo_protocol: got hung=%0d viol=%0d expected 0 0", r_hung, r_viol);
    end
    n_chk++;
    if (r_rsp_cyc - r_wait !== int'(TMO)) begin
      n_fail++;
      $display("FAIL tmo_delay: got %0d expected %0d", r_rsp_cyc - r_wait, TMO);
    end
    n_chk++;
    if ({r_write, r_resp, r_rdata} !== {1'b0, 2'b11, 32'h0}) begin
      n_fail++;
      $display("FAIL tmo_rsp: got w=%b resp=%b rdata=%h expected 0 11 0",
               r_write, r_resp, r_rdata);
    end
    n_chk++;
    if (r_late !== 0) begin
      n_fail++;
      $display("FAIL tmo_late_accept: got %0d expected 0", r_late);
    end
    n_chk++;
    if (txn_count !== exp_count) begin
      n_fail++;
      $display("FAIL tmo_count: got %0d expected %0d", txn_count, exp_count);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b1, 32'h44, 32'h0102_0304, 4'h3, 1, 0, 0, 0, 2'b01, 32'h0, 10, 1'b1);
    exp_count++;
    n_chk++;
    if (r_hung !== 0 || r_viol !== 0 || r_resp !== 2'b01) begin
      n_fail++;
      $display("FAIL b2b_first: got hung=%0d viol=%0d resp=%b expected 0 0 01",
               r_hung, r_viol, r_resp);
    end
    // cmd_valid was high at the response handshake edge; it must not have been taken.
    n_chk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_not_taken: got cmd_ready=%b busy=%b expected 1 0", cmd_ready, busy);
    end
    n_chk++;
    if (txn_count !== exp_count) begin
      n_fail++;
      $display("FAIL b2b_count1: got %0d expected %0d", txn_count, exp_count);
    end
    run_txn(1'b0, 32'h48, 32'h0, 4'h0, 0, 0, 2, 0, 2'b00, 32'h0BAD_F00D, 10, 1'b0);
    exp_count++;
    n_chk++;
    if (r_hung !== 0 || r_viol !== 0 || r_rdata !== 32'h0BAD_F00D) begin
      n_fail++;
      $display("FAIL b2b_second: got hung=%0d viol=%0d rdata=%h expected 0 0 0badf00d",
               r_hung, r_viol, r_rdata);
    end
    n_chk++;
    if (txn_count !== exp_count) begin
      n_fail++;
      $display("FAIL b2b_count2: got %0d expected %0d", txn_count, exp_count);
    end
  endtask

  task automatic test_random();
    bit          wr;
    logic [31:0] addr, wd, rd, exp_rdata;
    logic [3:0]  st;
    logic [1:0]  resp;
    for (int i = 0; i < 16; i++) begin
      wr = 1'($urandom);
      addr = $urandom; wd = $urandom; rd = $urandom;
      st = 4'($urandom); resp = 2'($urandom);
      run_txn(wr, addr, wd, st, int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 5)), resp, rd,
              int'($urandom_range(0, 3)), 1'b0);
      exp_count++;
      exp_rdata = wr ? 32'h0 : rd;
      n_chk++;
      if (r_hung !== 0 || r_viol !== 0 || r_late !== 0) begin
        n_fail++;
        $display("FAIL rand%0d_protocol: got hung=%0d viol=%0d late=%0d expected 0 0 0",
                 i, r_hung, r_viol, r_late);
      end
      n_chk++;
      if ({r_write, r_resp, r_rdata} !== {wr, resp, exp_rdata}) begin
        n_fail++;
        $display("FAIL rand%0d_rsp: got w=%b resp=%b rdata=%h expected %b %b %h",
                 i, r_write, r_resp, r_rdata, wr, resp, exp_rdata);
      end
      n_chk++;
      if (txn_count !== exp_count) begin
        n_fail++;
        $display("FAIL rand%0d_count: got %0d expected %0d", i, txn_count, exp_count);
      end
    end
  endtask

  task automatic test_wrap();
    force dut.txn_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.txn_count_q;
    @(negedge clk);
    exp_count = 32'hFFFF_FFFF;
    run_txn(1'b1, 32'h8, 32'h1, 4'h1, 0, 0, 0, 0, 2'b00, 32'h0, 0, 1'b0);
    exp_count++;
    n_chk++;
    if (txn_count !== exp_count || exp_count !== 32'h0) begin
      n_fail++;
      $display("FAIL count_wrap: got %h expected 00000000", txn_count);
    end
  endtask

  task automatic test_reset_in_wresp();
    int guard;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h500; cmd_wdata = 32'h77; cmd_wstrb = 4'hF;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 20) begin @(negedge clk); guard++; end
    @(negedge clk);
    cmd_valid = 1'b0; awready = 1'b1; wready = 1'b1;
    @(negedge clk);
    awready = 1'b0; wready = 1'b0;
    n_chk++;
    if (bready !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rstw_in_wresp: got bready=%b busy=%b expected 1 1", bready, busy);
    end
    #2 resetn = 1'b0;
    #1;
    n_chk++;
    if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy} !== 7'd0) begin
      n_fail++;
      $display("FAIL rstw_async_drop: got %b expected 0000000",
               {awvalid, wvalid, bready, arvalid, rready, rsp_valid, busy});
    end
    @(negedge clk);
    resetn = 1'b1;
    exp_count = '0;
    @(negedge clk);
    n_chk++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || txn_count !== exp_count) begin
      n_fail++;
      $display("FAIL rstw_after: got cmd_ready=%b busy=%b count=%0d expected 1 0 0",
               cmd_ready, busy, txn_count);
    end
    run_txn(1'b0, 32'h504, 32'h0, 4'h0, 0, 0, 0, 0, 2'b00, 32'h5555_AAAA, 0, 1'b0);
    exp_count++;
    n_chk++;
    if (r_hung !== 0 || r_viol !== 0 || r_rdata !== 32'h5555_AAAA || txn_count !== exp_count)
    begin
      n_fail++;
      $display("FAIL rstw_resume: got hung=%0d viol=%0d rdata=%h count=%0d expected 0 0 5555aaaa 1",
               r_hung, r_viol, r_rdata, txn_count);
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait();
    test_write_w_delay();
    test_read();
    test_read_timeout();
    test_back_to_back();
    test_random();
    test_wrap();
    test_reset_in_wresp();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
